holy_axi_ram: RTL and testbench

AXI4 burst slave backed by a 32-bit word memory array: the responder end of the data cache's AXI master port. It serves the cache's 128-beat INCR write-back and refill bursts, as well as shorter bursts, on the core's test and FPGA memory path. It handles one transaction at a time, with write priority, per-byte strobes, and range checking that returns SLVERR.

---
 rtl/holy_axi_ram_if.sv | 42 ++++
 rtl/holy_axi_ram.sv | 143 ++++++++++++++
 tb/tb_holy_axi_ram.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/holy_axi_ram_if.sv
// AXI4 channel bundle (4-bit IDs, 32-bit address/data) between a master and holy_axi_ram.
interface axi_if;
    logic        awvalid, awready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bvalid, bready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        arvalid, arready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid, rready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;

    modport slave (
        input  awvalid, awid, awaddr, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast, bready,
        input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
        output awready, wready, bvalid, bid, bresp,
        output arready, rvalid, rid, rdata, rresp, rlast
    );
    modport master (
        output awvalid, awid, awaddr, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast, bready,
        output arvalid, arid, araddr, arlen, arsize, arburst, rready,
        input  awready, wready, bvalid, bid, bresp,
        input  arready, rvalid, rid, rdata, rresp, rlast
    );
endinterface

// File: rtl/holy_axi_ram.sv
// Single-outstanding AXI4 burst slave over a 32-bit word RAM, write priority, SLVERR on range/protocol errors.
// Optional HOLY_AXI_RAM_FIXED_BURST_EN adds FIXED bursts and flags WRAP/reserved burst types.
module holy_axi_ram #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input logic  aclk,
    input logic  rst_n,
    axi_if.slave axi
);
    localparam int unsigned AW        = $clog2(MEM_WORDS);
    localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

    typedef enum logic [1:0] {IDLE, W_DATA, W_RESP, R_DATA} state_t;
    state_t r_state, w_next;

    logic [31:0] r_mem [MEM_WORDS];
    logic [31:0] r_addr;
    logic [7:0]  r_len, r_beat;
    logic [3:0]  r_id;
    logic        r_err, r_over, r_fixed;

    logic [31:0] w_off;
    logic        w_in_range;
    logic [AW-1:0] w_word;
    logic [31:0] w_addr_nxt;
    logic        w_idle, w_aw_hs, w_ar_hs, w_w_hs, w_r_hs, w_at_len, w_wr_en;
    logic [1:0]  w_burst;
    logic [2:0]  w_size;
    logic        w_fixed, w_burst_err, w_cfg_err;

    // Range check is a single unsigned compare on the offset, so addresses below BASE_ADDR wrap high and fail.
    assign w_off      = r_addr - BASE_ADDR;
    assign w_in_range = w_off < MEM_BYTES;
    assign w_word     = w_off[AW+1:2];
    assign w_addr_nxt = r_fixed ? r_addr : r_addr + 32'd4;
    assign w_at_len   = (r_beat == r_len);

    assign w_idle  = (r_state == IDLE);
    assign w_aw_hs = w_idle && axi.awvalid;
    assign w_ar_hs = w_idle && !axi.awvalid && axi.arvalid;
    assign w_w_hs  = (r_state == W_DATA) && axi.wvalid;
    assign w_r_hs  = (r_state == R_DATA) && axi.rready;
    assign w_wr_en = rst_n && w_w_hs && w_in_range && !r_over;

    assign w_burst   = w_aw_hs ? axi.awburst : axi.arburst;
    assign w_size    = w_aw_hs ? axi.awsize  : axi.arsize;
    assign w_cfg_err = (w_size != 3'b010) || w_burst_err;

`ifdef HOLY_AXI_RAM_FIXED_BURST_EN
    assign w_fixed     = (w_burst == 2'b00);
    assign w_burst_err = w_burst[1];
`else
    logic w_unused_burst;
    assign w_unused_burst = ^w_burst;
    assign w_fixed        = 1'b0;
    assign w_burst_err    = 1'b0;
`endif

    always_ff @(posedge aclk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        axi.awready = 1'b0;
        axi.arready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bid     = 4'd0;
        axi.bresp   = 2'b00;
        axi.rvalid  = 1'b0;
        axi.rid     = 4'd0;
        axi.rdata   = 32'd0;
        axi.rresp   = 2'b00;
        axi.rlast   = 1'b0;
        case (r_state)
            IDLE: begin
                axi.awready = 1'b1;
                axi.arready = !axi.awvalid;
                if (axi.awvalid)      w_next = W_DATA;
                else if (axi.arvalid) w_next = R_DATA;
            end
            W_DATA: begin
                axi.wready = 1'b1;
                if (axi.wvalid && axi.wlast) w_next = W_RESP;
            end
            W_RESP: begin
                axi.bvalid = 1'b1;
                axi.bid    = r_id;
                axi.bresp  = r_err ? 2'b10 : 2'b00;
                if (axi.bready) w_next = IDLE;
            end
            R_DATA: begin
                axi.rvalid = 1'b1;
                axi.rid    = r_id;
                axi.rdata  = w_in_range ? r_mem[w_word] : 32'd0;
                axi.rresp  = (r_err || !w_in_range) ? 2'b10 : 2'b00;
                axi.rlast  = w_at_len;
                if (axi.rready && w_at_len) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!rst_n) begin
            r_addr  <= 32'd0;
            r_len   <= 8'd0;
            r_beat  <= 8'd0;
            r_id    <= 4'd0;
            r_err   <= 1'b0;
            r_over  <= 1'b0;
            r_fixed <= 1'b0;
        end else if (w_aw_hs || w_ar_hs) begin
            r_addr  <= w_aw_hs ? axi.awaddr : axi.araddr;
            r_len   <= w_aw_hs ? axi.awlen  : axi.arlen;
            r_id    <= w_aw_hs ? axi.awid   : axi.arid;
            r_beat  <= 8'd0;
            r_err   <= w_cfg_err;
            r_over  <= 1'b0;
            r_fixed <= w_fixed;
        end else if (w_w_hs) begin
            r_addr <= w_addr_nxt;
            r_beat <= r_beat + 8'd1;
            if (!w_in_range || r_over || (axi.wlast && !w_at_len)) r_err <= 1'b1;
            // Once the declared length is used up, further beats are swallowed until wlast.
            if (w_at_len && !axi.wlast) r_over <= 1'b1;
        end else if (w_r_hs) begin
            r_addr <= w_addr_nxt;
            r_beat <= r_beat + 8'd1;
        end
    end

    always_ff @(posedge aclk) begin
        if (w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (axi.wstrb[i]) r_mem[w_word][8*i +: 8] <= axi.wdata[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_holy_axi_ram.sv
// Directed bench for holy_axi_ram: a word-array model predicts every B and R beat, a negedge monitor compares.
module tb_holy_axi_ram;
    logic aclk  = 1'b0;
    logic rst_n = 1'b0;
    always #5 aclk = ~aclk;

    axi_if axi();
    holy_axi_ram #(.MEM_WORDS(1024), .BASE_ADDR(32'h0)) dut (.aclk(aclk), .rst_n(rst_n), .axi(axi));

`ifdef HOLY_AXI_RAM_FIXED_BURST_EN
    localparam bit FIXED_EN = 1'b1;
`else
    localparam bit FIXED_EN = 1'b0;
`endif

    typedef struct { logic [31:0] data; logic [1:0] resp; logic last; logic [3:0] id; } rbeat_t;
    typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] m_mem [1024];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];
    rbeat_t exp_r[$];
    bexp_t  exp_b[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input int i, input logic [1:0] burst);
        return (FIXED_EN && burst == 2'b00) ? a : a + 32'(4 * i);
    endfunction
    function automatic logic in_range(input logic [31:0] a);
        return a < 32'd4096;
    endfunction
    function automatic logic [9:0] word_of(input logic [31:0] a);
        return a[11:2];
    endfunction
    function automatic logic cfg_err(input logic [2:0] size, input logic [1:0] burst);
        return (size != 3'b010) || (FIXED_EN && burst[1]);
    endfunction

    // Monitor: every R/B handshake against the model queues, plus R hold-stability under backpressure.
    logic pv, pl;
    logic [31:0] pd;
    logic [1:0] pr;
    rbeat_t ce;
    bexp_t  cb;
    initial begin
        pv = 1'b0; pl = 1'b0; pd = '0; pr = '0;
        forever begin
            @(negedge aclk);
            if (rst_n && pv) begin
                chk("r_hold_valid", 32'(axi.rvalid), 32'd1);
                chk("r_hold_data", axi.rdata, pd);
                chk("r_hold_resp", 32'(axi.rresp), 32'(pr));
                chk("r_hold_last", 32'(axi.rlast), 32'(pl));
            end
            pv = rst_n && axi.rvalid && !axi.rready;
            pd = axi.rdata; pr = axi.rresp; pl = axi.rlast;
            if (rst_n && axi.rvalid && axi.rready) begin
                chk("r_beat_expected", 32'(exp_r.size() != 0), 32'd1);
                if (exp_r.size() != 0) begin
                    ce = exp_r.pop_front();
                    chk("rdata", axi.rdata, ce.data);
                    chk("rresp", 32'(axi.rresp), 32'(ce.resp));
                    chk("rlast", 32'(axi.rlast), 32'(ce.last));
                    chk("rid", 32'(axi.rid), 32'(ce.id));
                end
            end
            if (rst_n && axi.bvalid && axi.bready) begin
                chk("b_expected", 32'(exp_b.size() != 0), 32'd1);
                if (exp_b.size() != 0) begin
                    cb = exp_b.pop_front();
                    chk("bresp", 32'(axi.bresp), 32'(cb.resp));
                    chk("bid", 32'(axi.bid), 32'(cb.id));
                end
            end
        end
    end

    task automatic set_ar(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id);
        axi.araddr = a; axi.arlen = len; axi.arsize = size; axi.arburst = burst; axi.arid = id;
    endtask

    task automatic do_aw(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id);
        axi.awaddr = a; axi.awlen = len; axi.awsize = size; axi.awburst = burst; axi.awid = id;
        axi.awvalid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge aclk);
            if (axi.arvalid) chk("ar_blocked_by_aw", 32'(axi.arready), 32'd0);
            if (axi.awready) break;
            if (t == 49) chk("aw_timeout", 32'(axi.awready), 32'd1);
            @(posedge aclk); #1;
        end
        @(posedge aclk); #1;
        axi.awvalid = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] id, input int last_at);
        logic err;
        logic [31:0] ad;
        bexp_t eb;
        err = cfg_err(size, burst);
        for (int i = 0; i <= last_at; i++) begin
            ad = beat_addr(a, i, burst);
            if (i > int'(len)) err = 1'b1;
            else if (!in_range(ad)) err = 1'b1;
            else for (int b = 0; b < 4; b++) if (ws[i][b]) m_mem[word_of(ad)][8*b +: 8] = wd[i][8*b +: 8];
            if (i == last_at && i != int'(len)) err = 1'b1;
        end
        eb.id = id; eb.resp = err ? 2'b10 : 2'b00;
        exp_b.push_back(eb);
        do_aw(a, len, size, burst, id);
        for (int i = 0; i <= last_at; i++) begin
            axi.wvalid = 1'b1; axi.wdata = wd[i]; axi.wstrb = ws[i]; axi.wlast = (i == last_at);
            @(negedge aclk);
            chk("wready", 32'(axi.wready), 32'd1);
            @(posedge aclk); #1;
        end
        axi.wvalid = 1'b0; axi.wlast = 1'b0;
        axi.bready = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge aclk);
            if (t == 0) chk("bvalid_after_wlast", 32'(axi.bvalid), 32'd1);
            if (axi.bvalid) break;
            @(posedge aclk); #1;
        end
        @(posedge aclk); #1;
        axi.bready = 1'b0;
    endtask

    // rmode 1 toggles rready every cycle starting low; stop_at >= 0 abandons the burst after that many beats.
    task automatic do_read(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input bit rmode, input int stop_at);
        rbeat_t e;
        logic [31:0] ad;
        int cnt;
        for (int i = 0; i <= int'(len); i++) begin
            ad = beat_addr(a, i, burst);
            e.data = in_range(ad) ? m_mem[word_of(ad)] : 32'd0;
            e.resp = (cfg_err(size, burst) || !in_range(ad)) ? 2'b10 : 2'b00;
            e.last = (i == int'(len));
            e.id   = id;
            exp_r.push_back(e);
        end
        set_ar(a, len, size, burst, id);
        axi.arvalid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge aclk);
            if (axi.arready) break;
            if (t == 299) chk("ar_timeout", 32'(axi.arready), 32'd1);
            @(posedge aclk); #1;
        end
        @(posedge aclk); #1;
        axi.arvalid = 1'b0;
        axi.rready = !rmode;
        cnt = 0;
        for (int t = 0; t < 4000 && cnt <= int'(len) && cnt != stop_at; t++) begin
            @(negedge aclk);
            if (t == 0) chk("rvalid_at_ar_plus1", 32'(axi.rvalid), 32'd1);
            if (axi.rvalid && axi.rready) cnt++;
            @(posedge aclk); #1;
            if (rmode) axi.rready = !axi.rready;
        end
        axi.rready = 1'b0;
        if (stop_at < 0) chk("r_beat_count", 32'(cnt), 32'(int'(len) + 1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        axi.awvalid = 0; axi.awid = 0; axi.awaddr = 0; axi.awlen = 0; axi.awsize = 0; axi.awburst = 0;
        axi.wvalid = 0; axi.wdata = 0; axi.wstrb = 0; axi.wlast = 0; axi.bready = 0;
        axi.arvalid = 0; axi.arid = 0; axi.araddr = 0; axi.arlen = 0; axi.arsize = 0; axi.arburst = 0;
        axi.rready = 0;
        repeat (3) @(posedge aclk);
        #1;
        @(negedge aclk);
        chk("rst_awready", 32'(axi.awready), 32'd1);
        chk("rst_arready", 32'(axi.arready), 32'd1);
        chk("rst_valids", {28'd0, axi.wready, axi.bvalid, axi.rvalid, axi.rlast}, 32'd0);
        chk("rst_resp_ids", {20'd0, axi.bresp, axi.rresp, axi.bid, axi.rid}, 32'd0);
        chk("rst_rdata", axi.rdata, 32'd0);
        @(posedge aclk); #1;
        rst_n = 1'b1;

        // Cache write-back then refill: 128 beats of i+1.
        for (int i = 0; i < 128; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        do_write(32'h0, 8'd127, 3'b010, 2'b01, 4'h3, 127);
        chk("model_wb_last_word", m_mem[127], 32'd128);
        do_read(32'h0, 8'd127, 3'b010, 2'b01, 4'h5, 1'b0, -1);

        // Byte strobes.
        wd[0] = 32'hAABBCCDD; ws[0] = 4'hF;
        do_write(32'h40, 8'd0, 3'b010, 2'b01, 4'h1, 0);
        wd[0] = 32'h11223344; ws[0] = 4'b0101;
        do_write(32'h40, 8'd0, 3'b010, 2'b01, 4'h2, 0);
        chk("model_strobe_merge", m_mem[16], 32'hAA22CC44);
        do_read(32'h40, 8'd0, 3'b010, 2'b01, 4'h7, 1'b0, -1);

        // AW and AR together: write wins, then the pending read with rready toggling.
        set_ar(32'h40, 8'd7, 3'b010, 2'b01, 4'h9);
        axi.arvalid = 1'b1;
        wd[0] = 32'hCAFEF00D; ws[0] = 4'hF;
        do_write(32'h80, 8'd0, 3'b010, 2'b01, 4'h8, 0);
        do_read(32'h40, 8'd7, 3'b010, 2'b01, 4'h9, 1'b1, -1);

        // Range error at top of memory.
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hD0 + 32'(i); ws[i] = 4'hF; end
        do_write(32'hFF8, 8'd3, 3'b010, 2'b01, 4'hA, 3);
        chk("model_range_written", m_mem[1023], 32'hD1);
        do_read(32'hFF8, 8'd3, 3'b010, 2'b01, 4'hB, 1'b0, -1);

        // Early wlast on beat 1 of len 3.
        for (int i = 0; i < 2; i++) begin wd[i] = 32'h5500 + 32'(i); ws[i] = 4'hF; end
        do_write(32'h100, 8'd3, 3'b010, 2'b01, 4'hC, 1);
        do_read(32'h100, 8'd1, 3'b010, 2'b01, 4'hC, 1'b0, -1);

        // Bad size and address wrap past 0xFFFF_FFFC.
        do_read(32'h0, 8'd1, 3'b001, 2'b01, 4'hD, 1'b0, -1);
        chk("model_wrap_addr", beat_addr(32'hFFFF_FFF8, 2, 2'b01), 32'h0);
        do_read(32'hFFFF_FFF8, 8'd3, 3'b010, 2'b01, 4'hE, 1'b0, -1);

        // Reset at beat 5 of a 128-beat read.
        do_read(32'h0, 8'd127, 3'b010, 2'b01, 4'h6, 1'b0, 5);
        rst_n = 1'b0;
        exp_r.delete();
        @(posedge aclk); #1;
        @(negedge aclk);
        chk("rst_mid_rvalid", 32'(axi.rvalid), 32'd0);
        chk("rst_mid_awready", 32'(axi.awready), 32'd1);
        @(posedge aclk); #1;
        rst_n = 1'b1;
        do_read(32'h0, 8'd127, 3'b010, 2'b01, 4'h4, 1'b0, -1);

        // Burst type 0: FIXED when enabled, INCR otherwise.
        do_read(32'h10, 8'd3, 3'b010, 2'b00, 4'hF, 1'b0, -1);

        repeat (2) @(posedge aclk);
        chk("r_queue_drained", 32'(exp_r.size()), 32'd0);
        chk("b_queue_drained", 32'(exp_b.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
